// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and constants for the LED matrix scanner: frame layout and scan states.
// Imported by the interface, the frame buffer and the scanner top.
package led_scan_pkg;

    localparam int N_ROWS = 16;
    localparam int N_COLS = 16;

    // [r][c] = row r, column c
    typedef logic [N_ROWS-1:0][N_COLS-1:0] pixel_frame_t;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame hand-off bus from the game-logic generators to the scanner.
// The master offers a red/green frame with frame_valid; the slave accepts while frame_ready is high.
interface led_matrix_scanner_if;
    import led_scan_pkg::*;

    pixel_frame_t RedPixels;
    pixel_frame_t GrnPixels;
    logic         frame_valid;
    logic         frame_ready;

    modport master (
        output RedPixels,
        output GrnPixels,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  RedPixels,
        input  GrnPixels,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/led_matrix_scanner_frame_buffer.sv
// Double buffer for the scanner: a staging frame filled by the accept handshake and a
// shadow frame that is displayed, refreshed from staging only when the scanner asks for a swap.
module led_frame_buffer
    import led_scan_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  pixel_frame_t      red_i,
    input  pixel_frame_t      grn_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              swap_i,
    input  logic [3:0]        row_idx_i,
    output logic [N_COLS-1:0] red_row_o,
    output logic [N_COLS-1:0] grn_row_o
);

    pixel_frame_t staging_red_q;
    pixel_frame_t staging_grn_q;
    pixel_frame_t shadow_red_q;
    pixel_frame_t shadow_grn_q;
    logic         pending_q;

    // Capture needs pending low and a swap needs it high, so the two never collide.
    // NOTE: both frame stores are cleared on reset because a reset must blank the
    // display; storage that is always written before being read would not need this.
    always_ff @(posedge clk) begin
        if (RST) begin
            staging_red_q <= '0;
            staging_grn_q <= '0;
            shadow_red_q  <= '0;
            shadow_grn_q  <= '0;
            pending_q     <= 1'b0;
        end else if (valid_i && !pending_q) begin
            staging_red_q <= red_i;
            staging_grn_q <= grn_i;
            pending_q     <= 1'b1;
        end else if (swap_i && pending_q) begin
            shadow_red_q  <= staging_red_q;
            shadow_grn_q  <= staging_grn_q;
            pending_q     <= 1'b0;
        end
    end

    assign ready_o   = !pending_q;
    assign red_row_o = shadow_red_q[row_idx_i];
    assign grn_row_o = shadow_grn_q[row_idx_i];

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-at-a-time LED matrix scanner: each row gets a dark blanking gap, then a dwell period
// of drive. New frames enter through a double buffer and are swapped in only after row 15.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 2048,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 enable,
    led_matrix_scanner_if.slave  frame_if,
    output logic [N_ROWS-1:0]    row_sel,
    output logic [3:0]           row_idx,
    output logic [N_COLS-1:0]    red_col,
    output logic [N_COLS-1:0]    grn_col,
    output logic                 frame_start
);

    localparam int unsigned CNT_W = $clog2(max_u(DWELL_CYCLES, BLANK_CYCLES) + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_e        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [3:0]         row_q;
    logic [3:0]         row_d;
    logic               blank_done;
    logic               dwell_done;
    logic               swap;
    logic [N_COLS-1:0]  red_row;
    logic [N_COLS-1:0]  grn_row;

    // NOTE: every signal assigned in a combinational block gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        row_d      = row_q + 4'd1;
        blank_done = (state_q == S_BLANK) && (cnt_q == BLANK_LAST);
        dwell_done = (state_q == S_DRIVE) && (cnt_q == DWELL_LAST);
        swap       = enable && dwell_done && (row_q == 4'd15);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            row_q   <= '0;
        end else if (!enable) begin
            // Freeze on the current row; re-enable restarts with a full blank gap.
            state_q <= S_BLANK;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_BLANK: begin
                    if (blank_done) begin
                        state_q <= S_DRIVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                S_DRIVE: begin
                    if (dwell_done) begin
                        state_q <= S_BLANK;
                        cnt_q   <= '0;
                        row_q   <= row_d;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= S_BLANK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    led_frame_buffer u_frame_buffer (
        .clk       (clk),
        .RST       (RST),
        .red_i     (frame_if.RedPixels),
        .grn_i     (frame_if.GrnPixels),
        .valid_i   (frame_if.frame_valid),
        .ready_o   (frame_if.frame_ready),
        .swap_i    (swap),
        .row_idx_i (row_q),
        .red_row_o (red_row),
        .grn_row_o (grn_row)
    );

    // Pin drive is a pure decode of the registered scan state.
    always_comb begin
        row_sel     = '0;
        red_col     = '0;
        grn_col     = '0;
        frame_start = 1'b0;
        if (state_q == S_DRIVE) begin
            row_sel     = N_ROWS'(1) << row_q;
            red_col     = red_row;
            grn_col     = grn_row;
            frame_start = (cnt_q == '0) && (row_q == 4'd0);
        end
    end

    assign row_idx = row_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (DWELL=4, BLANK=2, 96-cycle frame): directed
// scenarios plus a randomized phase, all checked every cycle against a slot/position model.
module tb_led_matrix_scanner;
    import led_scan_pkg::*;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = 16 * SLOT;

    logic        clk = 1'b0;
    logic        RST;
    logic        enable;
    logic [15:0] row_sel;
    logic [3:0]  row_idx;
    logic [15:0] red_col;
    logic [15:0] grn_col;
    logic        frame_start;

    always #5 clk = ~clk;

    led_matrix_scanner_if fif ();

    led_matrix_scanner #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .enable      (enable),
        .frame_if    (fif.slave),
        .row_sel     (row_sel),
        .row_idx     (row_idx),
        .red_col     (red_col),
        .grn_col     (grn_col),
        .frame_start (frame_start)
    );

    // Reference model: position within the current row slot plus row number.
    int           m_p;
    int           m_r;
    bit           m_pend;
    pixel_frame_t m_stage_r, m_stage_g, m_show_r, m_show_g;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_fs;
    int fs_count;
    bit track_fs = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit cap;
        if (RST) begin
            m_p = 0; m_r = 0; m_pend = 1'b0;
            m_stage_r = '0; m_stage_g = '0; m_show_r = '0; m_show_g = '0;
        end else begin
            cap = fif.frame_valid && !m_pend;
            if (!enable) begin
                m_p = 0;
            end else begin
                m_p++;
                if (m_p == SLOT) begin
                    m_p = 0;
                    if (m_r == 15 && m_pend) begin
                        m_show_r = m_stage_r;
                        m_show_g = m_stage_g;
                        m_pend   = 1'b0;
                    end
                    m_r = (m_r + 1) % 16;
                end
            end
            if (cap) begin
                m_stage_r = fif.RedPixels;
                m_stage_g = fif.GrnPixels;
                m_pend    = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        bit          drv;
        logic [15:0] e_sel, e_red, e_grn;
        drv   = (m_p >= BL);
        e_sel = drv ? (16'd1 << m_r) : 16'd0;
        e_red = drv ? m_show_r[m_r] : 16'd0;
        e_grn = drv ? m_show_g[m_r] : 16'd0;
        check("row_idx", 32'(row_idx), 32'(m_r));
        check("row_sel", 32'(row_sel), 32'(e_sel));
        check("red_col", 32'(red_col), 32'(e_red));
        check("grn_col", 32'(grn_col), 32'(e_grn));
        check("frame_start", 32'(frame_start), 32'(drv && m_p == BL && m_r == 0));
        check("frame_ready", 32'(fif.frame_ready), 32'(!m_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
        if (track_fs && frame_start === 1'b1) begin
            if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
            check("fs_row_sel", 32'(row_sel), 32'h0001);
            last_fs = cyc;
            fs_count++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Stops on the first drive cycle of row r; a missed deadline counts as a failure.
    task automatic wait_row_drive(input int r);
        bit hit = 1'b0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            tick();
            hit = (m_r == r) && (m_p == BL);
        end
        check("wait_row_timeout", 32'(hit), 32'd1);
    endtask

    task automatic random_frames();
        for (int i = 0; i < 16; i++) begin
            fif.RedPixels[i] = 16'($urandom());
            fif.GrnPixels[i] = 16'($urandom());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] col_or;
        bit          rdy_seen;

        RST             = 1'b1;
        enable          = 1'b1;
        fif.frame_valid = 1'b0;
        fif.RedPixels   = '0;
        fif.GrnPixels   = '0;

        // 1: reset and initial scan
        run(2);
        check("rst_row_sel", 32'(row_sel), 32'h0);
        check("rst_ready", 32'(fif.frame_ready), 32'd1);
        RST = 1'b0;
        tick();
        check("init_dark", 32'(row_sel), 32'h0);
        tick();
        check("init_row0", 32'(row_sel), 32'h0001);
        check("init_fs", 32'(frame_start), 32'd1);
        run(3);
        check("init_row0_last", 32'(row_sel), 32'h0001);
        run(2);
        check("init_gap", 32'(row_sel), 32'h0);
        tick();
        check("init_row1", 32'(row_sel), 32'h0002);

        // 2 + 3: frame load during row 3, second frame held under back-pressure
        wait_row_drive(3);
        fif.GrnPixels[0]  = 16'h0492;
        fif.GrnPixels[15] = 16'h0492;
        fif.frame_valid   = 1'b1;
        tick();
        check("load_ready_low", 32'(fif.frame_ready), 32'd0);
        fif.GrnPixels   = '0;
        fif.GrnPixels[7] = 16'h0080;
        wait_row_drive(15);
        check("old_row15", 32'(grn_col), 32'h0);
        rdy_seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !rdy_seen; i++) begin
            tick();
            rdy_seen = (fif.frame_ready === 1'b1);
        end
        check("ready_after_swap", 32'(rdy_seen), 32'd1);
        tick();
        check("bp_captured", 32'(fif.frame_ready), 32'd0);
        fif.frame_valid = 1'b0;
        fif.GrnPixels   = '0;
        wait_row_drive(0);
        check("new_row0", 32'(grn_col), 32'h0492);
        wait_row_drive(15);
        check("new_row15", 32'(grn_col), 32'h0492);
        wait_row_drive(0);
        check("second_row0", 32'(grn_col), 32'h0);
        wait_row_drive(7);
        check("second_row7", 32'(grn_col), 32'h0080);

        // 4: wrap and frame_start periodicity
        track_fs = 1'b1;
        last_fs  = -1;
        fs_count = 0;
        run(300);
        track_fs = 1'b0;
        check("fs_count", 32'(fs_count >= 3), 32'd1);

        // 5: enable freeze in the 2nd drive cycle of row 5
        wait_row_drive(5);
        tick();
        enable = 1'b0;
        tick();
        check("frz_dark", 32'(row_sel), 32'h0);
        check("frz_row", 32'(row_idx), 32'd5);
        run(5);
        check("frz_hold", 32'(row_idx), 32'd5);
        enable = 1'b1;
        tick();
        check("reen_dark", 32'(row_sel), 32'h0);
        for (int i = 0; i < DW; i++) begin
            tick();
            check("reen_row5", 32'(row_sel), 32'h0020);
        end
        tick();
        check("reen_gap", 32'(row_sel), 32'h0);

        // 6: reset mid-operation with a random frame pending
        wait_row_drive(2);
        random_frames();
        fif.frame_valid = 1'b1;
        tick();
        fif.frame_valid = 1'b0;
        check("rm_pending", 32'(fif.frame_ready), 32'd0);
        wait_row_drive(9);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rm_ready", 32'(fif.frame_ready), 32'd1);
        check("rm_row", 32'(row_idx), 32'd0);
        col_or = '0;
        for (int i = 0; i < FRAME + SLOT; i++) begin
            tick();
            col_or |= red_col | grn_col;
        end
        check("rm_cols_dark", 32'(col_or), 32'h0);

        // Randomized phase: random frames, valid strobes and enable drops
        for (int i = 0; i < 1200; i++) begin
            random_frames();
            fif.frame_valid = ($urandom_range(0, 3) == 0);
            enable          = ($urandom_range(0, 19) != 0);
            tick();
        end
        fif.frame_valid = 1'b0;
        enable          = 1'b1;
        run(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
